// File: rtl/loop_seq_ctrl_pkg.sv
// Shared definitions for the loop-nest sequencer.
//   - Default widths of the five loop indices (row, block, frame, patch, layer).
//   - FSM state type used by the sequencer top level.
package loop_seq_ctrl_pkg;

  localparam int unsigned ROW_W_DEF = 5;
  localparam int unsigned BLK_W_DEF = 6;
  localparam int unsigned FRM_W_DEF = 4;
  localparam int unsigned PAT_W_DEF = 4;
  localparam int unsigned LAY_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/loop_seq_ctrl_wrap_cnt.sv
// Wrapping counter, one per loop level of the nest.
//   clk    : clock
//   i_clr  : synchronous clear to 0 (highest priority)
//   i_inc  : advance by one; wraps to 0 when the count equals i_term
//   i_term : terminal (last) value of the count
//   o_cnt  : current count
//   o_last : count equals i_term
//   o_wrap : this increment wraps the counter (carry into the next level)
module wrap_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_cnt,
  output logic         o_last,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;
  logic         w_last;

  // Equality against the terminal only, so a full-width terminal never overflows.
  assign w_last = (r_cnt == i_term);

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= w_last ? '0 : r_cnt + W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = w_last;
  assign o_wrap = i_inc & w_last;

endmodule

// File: rtl/loop_seq_ctrl.sv
// Loop-nest sequencer: latches the CFG_* values on start and walks the nest
// layer > patch > frame > block > row, issuing one valid/ready step per row.
//   clk, rst_n     : clock; synchronous active-high reset (asserted = 1)
//   start          : one-cycle pulse, accepted only in IDLE
//   CFG_*          : nest configuration, sampled in LOAD
//   seq_vld/seq_rdy: step handshake towards the row scheduler
//   idx_*          : current loop indices
//   last_*         : index is at its terminal value (only while running)
//   dep_blk        : latched CFG_DepBlk
//   busy/done      : status; done pulses once at nest completion
//   cfg_err        : sticky zero-count error, cleared by next start or reset
module loop_seq_ctrl
  import loop_seq_ctrl_pkg::*;
#(
  parameter int unsigned ROW_W = ROW_W_DEF,
  parameter int unsigned BLK_W = BLK_W_DEF,
  parameter int unsigned FRM_W = FRM_W_DEF,
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned LAY_W = LAY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ROW_W-1:0] CFG_LenRow,
  input  logic [BLK_W-1:0] CFG_DepBlk,
  input  logic [BLK_W-1:0] CFG_NumBlk,
  input  logic [FRM_W-1:0] CFG_NumFrm,
  input  logic [PAT_W-1:0] CFG_NumPat,
  input  logic [LAY_W-1:0] CFG_NumLay,
  output logic             seq_vld,
  input  logic             seq_rdy,
  output logic [ROW_W-1:0] idx_row,
  output logic [BLK_W-1:0] idx_blk,
  output logic [FRM_W-1:0] idx_frm,
  output logic [PAT_W-1:0] idx_pat,
  output logic [LAY_W-1:0] idx_lay,
  output logic             last_row,
  output logic             last_blk,
  output logic             last_frm,
  output logic             last_pat,
  output logic             last_lay,
  output logic [BLK_W-1:0] dep_blk,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  seq_state_e r_state;
  logic       r_seq_vld;
  logic       r_busy;
  logic       r_done;
  logic       r_cfg_err;

  logic [ROW_W-1:0] r_len_row;
  logic [BLK_W-1:0] r_dep_blk;
  logic [BLK_W-1:0] r_num_blk;
  logic [FRM_W-1:0] r_num_frm;
  logic [PAT_W-1:0] r_num_pat;
  logic [LAY_W-1:0] r_num_lay;

  logic w_clr;
  logic w_hs;
  logic w_run;
  logic w_cfg_zero;
  logic w_wrap_row, w_wrap_blk, w_wrap_frm, w_wrap_pat, w_wrap_lay;
  logic w_last_row, w_last_blk, w_last_frm, w_last_pat, w_last_lay;

  // seq_vld is only ever high in RUN, so the handshake needs no state term.
  assign w_hs       = r_seq_vld & seq_rdy;
  assign w_run      = (r_state == ST_RUN);
  assign w_clr      = rst_n | (r_state == ST_LOAD);
  assign w_cfg_zero = (CFG_NumBlk == '0) | (CFG_NumFrm == '0) |
                      (CFG_NumPat == '0) | (CFG_NumLay == '0);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state   <= ST_IDLE;
      r_seq_vld <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_len_row <= '0;
      r_dep_blk <= '0;
      r_num_blk <= '0;
      r_num_frm <= '0;
      r_num_pat <= '0;
      r_num_lay <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_LOAD;
            r_busy    <= 1'b1;
            r_cfg_err <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_len_row <= CFG_LenRow;
          r_dep_blk <= CFG_DepBlk;
          r_num_blk <= CFG_NumBlk;
          r_num_frm <= CFG_NumFrm;
          r_num_pat <= CFG_NumPat;
          r_num_lay <= CFG_NumLay;
          if (w_cfg_zero) begin
            r_state   <= ST_DONE;
            r_cfg_err <= 1'b1;
            r_done    <= 1'b1;
          end else begin
            r_state   <= ST_RUN;
            r_seq_vld <= 1'b1;
          end
        end
        ST_RUN: begin
          // Outermost wrap on a handshake is the final step of the nest.
          if (w_wrap_lay) begin
            r_state   <= ST_DONE;
            r_seq_vld <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  wrap_cnt #(.W(ROW_W)) u_cnt_row (
    .clk(clk), .i_clr(w_clr), .i_inc(w_hs), .i_term(r_len_row),
    .o_cnt(idx_row), .o_last(w_last_row), .o_wrap(w_wrap_row)
  );

  wrap_cnt #(.W(BLK_W)) u_cnt_blk (
    .clk(clk), .i_clr(w_clr), .i_inc(w_wrap_row), .i_term(r_num_blk - BLK_W'(1)),
    .o_cnt(idx_blk), .o_last(w_last_blk), .o_wrap(w_wrap_blk)
  );

  wrap_cnt #(.W(FRM_W)) u_cnt_frm (
    .clk(clk), .i_clr(w_clr), .i_inc(w_wrap_blk), .i_term(r_num_frm - FRM_W'(1)),
    .o_cnt(idx_frm), .o_last(w_last_frm), .o_wrap(w_wrap_frm)
  );

  wrap_cnt #(.W(PAT_W)) u_cnt_pat (
    .clk(clk), .i_clr(w_clr), .i_inc(w_wrap_frm), .i_term(r_num_pat - PAT_W'(1)),
    .o_cnt(idx_pat), .o_last(w_last_pat), .o_wrap(w_wrap_pat)
  );

  wrap_cnt #(.W(LAY_W)) u_cnt_lay (
    .clk(clk), .i_clr(w_clr), .i_inc(w_wrap_pat), .i_term(r_num_lay - LAY_W'(1)),
    .o_cnt(idx_lay), .o_last(w_last_lay), .o_wrap(w_wrap_lay)
  );

  // Outside RUN the latched terminals are meaningless (0 - 1 after reset),
  // so the last flags are held low there.
  assign last_row = w_last_row & w_run;
  assign last_blk = w_last_blk & w_run;
  assign last_frm = w_last_frm & w_run;
  assign last_pat = w_last_pat & w_run;
  assign last_lay = w_last_lay & w_run;

  assign seq_vld = r_seq_vld;
  assign dep_blk = r_dep_blk;
  assign busy    = r_busy;
  assign done    = r_done;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_loop_seq_ctrl.sv
// Directed self-checking bench for loop_seq_ctrl.
module tb_loop_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [4:0] CFG_LenRow = '0;
  logic [5:0] CFG_DepBlk = '0;
  logic [5:0] CFG_NumBlk = '0;
  logic [3:0] CFG_NumFrm = '0;
  logic [3:0] CFG_NumPat = '0;
  logic [3:0] CFG_NumLay = '0;
  logic       seq_rdy = 1'b0;
  logic       seq_vld;
  logic [4:0] idx_row;
  logic [5:0] idx_blk;
  logic [3:0] idx_frm, idx_pat, idx_lay;
  logic       last_row, last_blk, last_frm, last_pat, last_lay;
  logic [5:0] dep_blk;
  logic       busy, done, cfg_err;

  logic [22:0] w_idx_all;
  logic [4:0]  w_last_all;
  assign w_idx_all  = {idx_lay, idx_pat, idx_frm, idx_blk, idx_row};
  assign w_last_all = {last_lay, last_pat, last_frm, last_blk, last_row};

  int errors = 0;
  int checks = 0;

  // Snapshot of the configuration the DUT should have latched.
  int cfg_lr, cfg_blk, cfg_frm, cfg_pat, cfg_lay, cfg_dep;
  logic [22:0] exp_q[$];

  loop_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .CFG_LenRow(CFG_LenRow), .CFG_DepBlk(CFG_DepBlk), .CFG_NumBlk(CFG_NumBlk),
    .CFG_NumFrm(CFG_NumFrm), .CFG_NumPat(CFG_NumPat), .CFG_NumLay(CFG_NumLay),
    .seq_vld(seq_vld), .seq_rdy(seq_rdy),
    .idx_row(idx_row), .idx_blk(idx_blk), .idx_frm(idx_frm),
    .idx_pat(idx_pat), .idx_lay(idx_lay),
    .last_row(last_row), .last_blk(last_blk), .last_frm(last_frm),
    .last_pat(last_pat), .last_lay(last_lay),
    .dep_blk(dep_blk), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected step order as a plain nested loop over the configuration.
  task automatic build_exp();
    exp_q.delete();
    for (int l = 0; l < cfg_lay; l++)
      for (int p = 0; p < cfg_pat; p++)
        for (int f = 0; f < cfg_frm; f++)
          for (int b = 0; b < cfg_blk; b++)
            for (int r = 0; r <= cfg_lr; r++)
              exp_q.push_back({4'(l), 4'(p), 4'(f), 6'(b), 5'(r)});
  endtask

  function automatic logic [4:0] exp_last(input logic [22:0] e);
    exp_last = {int'(e[22:19]) == cfg_lay - 1, int'(e[18:15]) == cfg_pat - 1,
                int'(e[14:11]) == cfg_frm - 1, int'(e[10:5]) == cfg_blk - 1,
                int'(e[4:0]) == cfg_lr};
  endfunction

  // Pulses start with the given config, checks the LOAD cycle and, for a
  // valid config, the first RUN cycle (start + 2).
  task automatic start_cfg(input string tag, input int lr, input int blk, input int frm,
                           input int pat, input int lay, input int dep);
    cfg_lr = lr; cfg_blk = blk; cfg_frm = frm; cfg_pat = pat; cfg_lay = lay; cfg_dep = dep;
    CFG_LenRow = 5'(lr); CFG_NumBlk = 6'(blk); CFG_NumFrm = 4'(frm);
    CFG_NumPat = 4'(pat); CFG_NumLay = 4'(lay); CFG_DepBlk = 6'(dep);
    build_exp();
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_load_busy"}, 32'(busy), 32'd1);
    check({tag, "_load_vld"}, 32'(seq_vld), 32'd0);
    check({tag, "_load_err"}, 32'(cfg_err), 32'd0);
    tick();
    if (blk != 0 && frm != 0 && pat != 0 && lay != 0) begin
      check({tag, "_first_vld"}, 32'(seq_vld), 32'd1);
      check({tag, "_first_idx"}, 32'(w_idx_all), 32'd0);
      check({tag, "_dep_blk"}, 32'(dep_blk), 32'(dep));
    end
  endtask

  // mode 0: always ready; mode 1: ready one cycle in three;
  // mode 2: always ready, with a stray start and a CFG_LenRow change mid-run.
  task automatic run_nest(input string tag, input int mode);
    int   n_hs;
    int   last_c;
    bit   got;
    bit   stalled;
    logic rdy;
    logic [22:0] prev;
    n_hs = 0; last_c = -100; got = 1'b0; stalled = 1'b0; prev = '0;
    for (int c = 0; c < 400 && !got; c++) begin
      if (done) begin
        got = 1'b1;
        check({tag, "_done_lat"}, 32'(c - last_c), 32'd1);
        check({tag, "_done_vld"}, 32'(seq_vld), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd1);
      end else begin
        if (stalled) check({tag, "_stall_hold"}, 32'(w_idx_all), 32'(prev));
        rdy = (mode == 1) ? (c % 3 == 2) : 1'b1;
        if (mode == 2) begin
          start = (c == 3);
          if (c == 3) CFG_LenRow = 5'd7;
        end
        seq_rdy = rdy;
        if (seq_vld && rdy) begin
          if (n_hs < exp_q.size()) begin
            check({tag, "_idx"}, 32'(w_idx_all), 32'(exp_q[n_hs]));
            check({tag, "_last"}, 32'(w_last_all), 32'(exp_last(exp_q[n_hs])));
          end
          n_hs++;
          last_c = c;
        end
        stalled = seq_vld && !rdy;
        prev = w_idx_all;
        tick();
      end
    end
    seq_rdy = 1'b0;
    start = 1'b0;
    check({tag, "_hs_count"}, 32'(n_hs), 32'(exp_q.size()));
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    tick();
    check({tag, "_post_done"}, 32'(done), 32'd0);
    check({tag, "_post_busy"}, 32'(busy), 32'd0);
    check({tag, "_post_vld"}, 32'(seq_vld), 32'd0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b1;
    tick();
    tick();
    check("rst_ctl", 32'({busy, done, cfg_err, seq_vld, w_last_all}), 32'd0);
    check("rst_idx", 32'(w_idx_all), 32'd0);
    check("rst_dep", 32'(dep_blk), 32'd0);
    rst_n = 1'b0;
    tick();

    // 1: 2 rows x 2 blocks x 2 layers, always ready -> 8 steps
    start_cfg("t1", 1, 2, 1, 1, 2, 9);
    run_nest("t1", 0);

    // 2: same config, consumer ready one cycle in three
    start_cfg("t2", 1, 2, 1, 1, 2, 9);
    run_nest("t2", 1);

    // 3: zero frame count -> error, done at start + 2, no steps
    start_cfg("t3", 1, 2, 0, 1, 2, 3);
    check("t3_done", 32'(done), 32'd1);
    check("t3_err", 32'(cfg_err), 32'd1);
    check("t3_vld", 32'(seq_vld), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    tick();
    check("t3_done_off", 32'(done), 32'd0);
    check("t3_err_sticky", 32'(cfg_err), 32'd1);
    check("t3_idle_busy", 32'(busy), 32'd0);
    check("t3_vld_off", 32'(seq_vld), 32'd0);

    // 4: next valid start clears cfg_err (checked in LOAD); stray start and
    // CFG_LenRow change during RUN are ignored
    start_cfg("t4", 1, 2, 1, 1, 2, 5);
    run_nest("t4", 2);
    CFG_LenRow = 5'd1;

    // 5: reset after 3 steps, then a fresh run from zero
    start_cfg("t5", 1, 2, 1, 1, 2, 7);
    seq_rdy = 1'b1;
    tick();
    tick();
    tick();
    check("t5_mid_idx", 32'(w_idx_all), 32'(exp_q[3]));
    rst_n = 1'b1;
    seq_rdy = 1'b0;
    tick();
    check("t5_rst_ctl", 32'({busy, done, cfg_err, seq_vld, w_last_all}), 32'd0);
    check("t5_rst_idx", 32'(w_idx_all), 32'd0);
    check("t5_rst_dep", 32'(dep_blk), 32'd0);
    rst_n = 1'b0;
    tick();
    check("t5_no_done", 32'({done, busy, seq_vld}), 32'd0);
    start_cfg("t5b", 1, 2, 1, 1, 2, 7);
    run_nest("t5b", 0);

    // 6: full-width row count, 32 steps
    start_cfg("t6", 31, 1, 1, 1, 1, 63);
    run_nest("t6", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
